matrix_write_responder: RTL and testbench
=========================================

Name: matrix_write_responder

Overview:
- Storage-side responder for the matrix write protocol: write_request/write_ready, writer_ready, write_data/write_data_valid, write_done.
- Accepts one matrix job at a time (id, dims, 8-byte name), writes a 3-word header and row-major data into that id's BRAM region, then pulses write_done.
- Tracks which of the 8 matrix slots hold valid contents.
- Sits between the op executor / op modules and the matrix BRAM write port.

Parameters:
- BLOCK_SIZE, 1152, words per matrix slot; slot base = id*BLOCK_SIZE.
- ADDR_WIDTH, 14, BRAM address width.
- DATA_WIDTH, 32, BRAM/data word width.
- MAX_DIM, 32, maximum legal rows or cols.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- write_request  input  1  initiator requests a job
- write_ready  output  1  responder can accept a request (IDLE)
- write_matrix_id  input  3  target slot
- write_rows  input  8  row count
- write_cols  input  8  column count
- write_name  input  8x8 (array [0:7])  ASCII name, [0] first
- write_data  input  DATA_WIDTH  data beat
- write_data_valid  input  1  beat strobe
- writer_ready  output  1  data beats accepted this cycle
- write_done  output  1  one-cycle completion pulse
- write_error  output  1  one-cycle pulse with write_done on rejected job
- bram_we  output  1  BRAM write enable
- bram_addr  output  ADDR_WIDTH  BRAM write address
- bram_din  output  DATA_WIDTH  BRAM write data
- matrix_valid  output  8  per-slot valid flags
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, all counters/latches 0.
  - Output reset values: write_ready=1, writer_ready=0, write_done=0, write_error=0, bram_we=0, bram_addr=0, bram_din=0, matrix_valid=0, busy=0.
- States: IDLE, HDR0, HDR1, HDR2, DATA, DONE, ERROR.
- IDLE: write_ready=1. On write_request=1 at a clock edge:
  - Latch id, rows, cols and name.
  - If rows==0, cols==0, rows>MAX_DIM or cols>MAX_DIM: go to ERROR.
  - Otherwise clear matrix_valid[id] and go to HDR0.
- write_ready is 0 in every state other than IDLE. Requests outside IDLE are ignored and never queued.
- Header (one word per state, HDR0..HDR2):
  - HDR0: bram_we=1, addr=base+0, din={rows,cols,16'h0}.
  - HDR1: addr=base+1, din={name[0],name[1],name[2],name[3]}, name[0] in bits 31:24.
  - HDR2: addr=base+2, din={name[4..7]}.
- Header timing: header words appear on the BRAM port in cycles 1, 2 and 3 after the acceptance edge.
- Address arithmetic: base = id*BLOCK_SIZE, computed at ADDR_WIDTH bits with no wrap. Element k goes to base+3+k. Total elements N = rows*cols (16-bit product, ≤ MAX_DIM²).
- DATA:
  - writer_ready=1 (decoded from state); first high in cycle 4 after acceptance.
  - Each edge with write_data_valid=1 writes write_data to base+3+count and increments count.
  - Gaps (valid=0) produce no write and hold count.
  - BRAM outputs are registered: a beat sampled at edge E is on bram_* during the cycle after E.
  - The edge taking beat N-1 moves the FSM to DONE, so writer_ready falls the next cycle. Extra valid beats are dropped.
- DONE: write_done=1 for exactly one cycle, matrix_valid[id] set, then IDLE. write_ready returns 1 the following cycle.
- ERROR: write_done=1 and write_error=1 for one cycle, then IDLE.
  - No BRAM write occurs.
  - matrix_valid is unchanged.
  - writer_ready never rises.
- write_data_valid outside DATA is ignored (no BRAM write).
- Reset during any state aborts immediately: a partially written slot stays invalid (matrix_valid cleared), no write_done.
- Back-to-back jobs: a new request is accepted in the first IDLE cycle after DONE/ERROR. Minimum job period is N+5 cycles.

Test Plan:
- 2x3 job to id 2, name "MAT2", data 1..6 streamed continuously -> writes 0x0203_0000@2304, 0x4D41_5432@2305, 0x0000_0000@2306, then 1..6 @2307..2312; write_done exactly one cycle; matrix_valid=8'h04.
- 1x1 job to id 7, name "SCALAR", data 0x0000_0005, valid asserted one cycle after writer_ready -> 0x0101_0000@8064, 0x5343_414C@8065, 0x4152_0000@8066, 5@8067; matrix_valid[7]=1.
- Reject cases rows=0,cols=4 and rows=33,cols=1 to id 3 -> write_done and write_error pulse together, bram_we never high, matrix_valid unchanged, writer_ready stays 0.
- 4x4 job with valid toggling 1,0,0,1,... plus 3 extra beats after the 16th -> exactly 16 writes at consecutive addresses; extras produce no bram_we.
- Second write_request while DATA is active for id 1 -> ignored; first job completes unchanged. Re-request after write_done is accepted and overwrites id 1, matrix_valid[1] low from acceptance until its DONE.
- rst asserted after 5 of 9 beats of a 3x3 job -> all outputs return to reset values asynchronously, matrix_valid=0, no write_done; a fresh job after reset completes normally.

Source files
------------

// File: rtl/matrix_write_responder.sv
// matrix_write_responder: accepts one matrix job, writes header plus row-major data into its BRAM slot
module matrix_write_responder #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            write_matrix_id,
  input  logic [7:0]            write_rows,
  input  logic [7:0]            write_cols,
  input  logic [7:0]            write_name [0:7],
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [7:0]            matrix_valid,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA, DONE, ERROR} state_t;
  state_t state;
  logic [2:0] id;
  logic [7:0] rows, cols;
  logic [7:0] name [0:7];
  logic [15:0] count, total;
  logic [ADDR_WIDTH-1:0] base, base_in;
  logic bad;
  assign total = {8'h0, rows} * {8'h0, cols};
  assign base = ADDR_WIDTH'(BLOCK_SIZE) * ADDR_WIDTH'(id);
  assign base_in = ADDR_WIDTH'(BLOCK_SIZE) * ADDR_WIDTH'(write_matrix_id);
  assign bad = write_rows == 8'd0 || write_cols == 8'd0 ||
               write_rows > 8'(MAX_DIM) || write_cols > 8'(MAX_DIM);
  assign write_ready = state == IDLE;
  assign writer_ready = state == DATA;
  assign write_done = state == DONE || state == ERROR;
  assign write_error = state == ERROR;
  assign busy = state != IDLE;
  // bram_* are loaded on the edge that enters each state, so each word is visible during that state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      id <= '0;
      rows <= '0;
      cols <= '0;
      for (int i = 0; i < 8; i++) name[i] <= '0;
      count <= '0;
      bram_we <= 1'b0;
      bram_addr <= '0;
      bram_din <= '0;
      matrix_valid <= '0;
    end else begin
      bram_we <= 1'b0;
      case (state)
        IDLE: if (write_request) begin
          id <= write_matrix_id;
          rows <= write_rows;
          cols <= write_cols;
          name <= write_name;
          count <= '0;
          if (bad) state <= ERROR;
          else begin
            state <= HDR0;
            matrix_valid[write_matrix_id] <= 1'b0;
            bram_we <= 1'b1;
            bram_addr <= base_in;
            bram_din <= DATA_WIDTH'({write_rows, write_cols, 16'h0});
          end
        end
        HDR0: begin
          state <= HDR1;
          bram_we <= 1'b1;
          bram_addr <= base + ADDR_WIDTH'(1);
          bram_din <= DATA_WIDTH'({name[0], name[1], name[2], name[3]});
        end
        HDR1: begin
          state <= HDR2;
          bram_we <= 1'b1;
          bram_addr <= base + ADDR_WIDTH'(2);
          bram_din <= DATA_WIDTH'({name[4], name[5], name[6], name[7]});
        end
        HDR2: state <= DATA;
        DATA: if (write_data_valid) begin
          bram_we <= 1'b1;
          bram_addr <= base + ADDR_WIDTH'(3) + ADDR_WIDTH'(count);
          bram_din <= write_data;
          count <= count + 16'd1;
          if (count == total - 16'd1) begin
            state <= DONE;
            matrix_valid[id] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_write_responder.sv
// tb_matrix_write_responder: directed jobs with a BRAM-write scoreboard and slot-valid model
module tb_matrix_write_responder;
  localparam int BS = 1152;
  logic clk = 1'b0, rst = 1'b1, write_request = 1'b0;
  logic [2:0] write_matrix_id = '0;
  logic [7:0] write_rows = '0, write_cols = '0;
  logic [7:0] write_name [0:7];
  logic [31:0] write_data = '0;
  logic write_data_valid = 1'b0;
  logic write_ready, writer_ready, write_done, write_error, bram_we, busy;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;
  logic [7:0] matrix_valid;
  logic [45:0] q [$];
  logic [7:0] mv = '0;
  int total = 0, bad = 0, done_cnt = 0;

  matrix_write_responder dut (
    .clk(clk), .rst(rst), .write_request(write_request), .write_ready(write_ready),
    .write_matrix_id(write_matrix_id), .write_rows(write_rows), .write_cols(write_cols),
    .write_name(write_name), .write_data(write_data), .write_data_valid(write_data_valid),
    .writer_ready(writer_ready), .write_done(write_done), .write_error(write_error),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .matrix_valid(matrix_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (write_done) done_cnt++;
    if (bram_we) begin
      chk("sb_entry_available", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("bram_write", 64'({bram_addr, bram_din}), 64'(q.pop_front()));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c, input logic [63:0] nm);
    logic [13:0] b;
    b = 14'(int'(id) * BS);
    write_matrix_id = id;
    write_rows = r;
    write_cols = c;
    for (int i = 0; i < 8; i++) write_name[i] = nm[63-8*i -: 8];
    write_request = 1'b1;
    if (r != 0 && c != 0 && r <= 32 && c <= 32) begin
      q.push_back({b, r, c, 16'h0});
      q.push_back({b + 14'd1, nm[63:32]});
      q.push_back({b + 14'd2, nm[31:0]});
    end
    step;
    write_request = 1'b0;
  endtask

  task automatic job(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c, input logic [63:0] nm,
                     input logic [31:0] d0, input int lead, input bit gap, input int extra, input bit intrude);
    int n, k, cyc;
    logic v;
    logic [13:0] b;
    logic [7:0] mid;
    n = int'(r) * int'(c);
    k = 0;
    cyc = 0;
    b = 14'(int'(id) * BS);
    mid = mv & ~(8'd1 << id);
    start(id, r, c, nm);
    repeat (3) begin
      chk("hdr_writer_ready", 64'(writer_ready), 64'd0);
      chk("hdr_busy", 64'(busy), 64'd1);
      chk("hdr_matrix_valid", 64'(matrix_valid), 64'(mid));
      step;
    end
    while (k < n) begin
      v = cyc < lead ? 1'b0 : gap ? ((cyc - lead) % 3 == 0) : 1'b1;
      write_data_valid = v;
      write_data = d0 + 32'(k);
      if (intrude) begin
        write_request = cyc == 1;
        write_matrix_id = cyc == 1 ? 3'd5 : id;
      end
      chk("data_writer_ready", 64'(writer_ready), 64'd1);
      chk("data_write_ready", 64'(write_ready), 64'd0);
      if (v) begin
        q.push_back({b + 14'd3 + 14'(k), d0 + 32'(k)});
        k++;
      end
      step;
      cyc++;
    end
    write_request = 1'b0;
    write_data_valid = extra > 0;
    mv = mid | (8'd1 << id);
    chk("done_pulse", 64'(write_done), 64'd1);
    chk("done_error", 64'(write_error), 64'd0);
    chk("done_writer_ready", 64'(writer_ready), 64'd0);
    chk("done_matrix_valid", 64'(matrix_valid), 64'(mv));
    step;
    chk("idle_done", 64'(write_done), 64'd0);
    chk("idle_write_ready", 64'(write_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("sb_drained", 64'(q.size()), 64'd0);
    for (int i = 2; i < extra; i++) begin
      step;
      chk("extra_write_ready", 64'(write_ready), 64'd1);
    end
    write_data_valid = 1'b0;
  endtask

  task automatic rej(input logic [7:0] r, input logic [7:0] c);
    start(3'd3, r, c, 64'h4241440000000000);
    write_data_valid = 1'b1;
    chk("rej_done", 64'(write_done), 64'd1);
    chk("rej_error", 64'(write_error), 64'd1);
    chk("rej_writer_ready", 64'(writer_ready), 64'd0);
    chk("rej_bram_we", 64'(bram_we), 64'd0);
    step;
    write_data_valid = 1'b0;
    chk("rej_done_cleared", 64'({write_done, write_error}), 64'd0);
    chk("rej_write_ready", 64'(write_ready), 64'd1);
    chk("rej_matrix_valid", 64'(matrix_valid), 64'(mv));
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 8; i++) write_name[i] = '0;
    step;
    step;
    chk("rst_outputs", 64'({write_ready, writer_ready, write_done, write_error, bram_we, busy}), 64'b100000);
    chk("rst_bram", 64'({bram_addr, bram_din}), 64'd0);
    chk("rst_matrix_valid", 64'(matrix_valid), 64'd0);
    rst = 1'b0;
    step;
    job(3'd2, 8'd2, 8'd3, 64'h4D41543200000000, 32'd1, 0, 1'b0, 0, 1'b0);
    chk("t1_matrix_valid", 64'(matrix_valid), 64'h04);
    job(3'd7, 8'd1, 8'd1, 64'h5343414C41520000, 32'd5, 1, 1'b0, 0, 1'b0);
    chk("t2_matrix_valid", 64'(matrix_valid), 64'h84);
    job(3'd3, 8'd1, 8'd2, 64'h4D33000000000000, 32'h100, 0, 1'b0, 0, 1'b0);
    rej(8'd0, 8'd4);
    rej(8'd33, 8'd1);
    rej(8'd1, 8'd33);
    job(3'd0, 8'd4, 8'd4, 64'h4741505059000000, 32'hA0, 0, 1'b1, 3, 1'b0);
    job(3'd1, 8'd2, 8'd2, 64'h4F4E450000000000, 32'h10, 0, 1'b0, 0, 1'b1);
    job(3'd1, 8'd3, 8'd1, 64'h4F4E453200000000, 32'h20, 0, 1'b0, 0, 1'b0);
    chk("rerequest_matrix_valid", 64'(matrix_valid), 64'h8F);
    job(3'd5, 8'd32, 8'd32, 64'h4D41585858580000, 32'h1000, 0, 1'b0, 0, 1'b0);
    start(3'd4, 8'd3, 8'd3, 64'h5253540000000000);
    repeat (3) step;
    for (int k = 0; k < 5; k++) begin
      write_data_valid = 1'b1;
      write_data = 32'h500 + 32'(k);
      q.push_back({14'(4 * BS + 3 + k), 32'h500 + 32'(k)});
      step;
    end
    write_data_valid = 1'b0;
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_outputs", 64'({write_ready, writer_ready, write_done, write_error, bram_we, busy}), 64'b100000);
    chk("arst_bram", 64'({bram_addr, bram_din}), 64'd0);
    chk("arst_matrix_valid", 64'(matrix_valid), 64'd0);
    q.delete();
    mv = '0;
    step;
    rst = 1'b0;
    step;
    chk("arst_no_done", 64'(done_cnt), 64'(dc));
    job(3'd6, 8'd2, 8'd2, 64'h4641524553480000, 32'h77, 0, 1'b0, 0, 1'b0);
    chk("post_rst_matrix_valid", 64'(matrix_valid), 64'h40);
    repeat (3) step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
